// File: rtl/i_decode_issue_if.sv
// rtl/i_decode_issue_if.sv - instruction-in, ALU-out and writeback signals of the decode/issue stage
interface i_decode_issue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [11:0]     imm;
  logic [XLEN-1:0] in1;
  logic [4:0]      rd;
  logic            illegal;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    output in_ready, out_valid, opcode, funct3, imm, in1, rd, illegal
  );

  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    input  in_ready, out_valid, opcode, funct3, imm, in1, rd, illegal
  );
endinterface

// File: rtl/i_decode_issue.sv
// rtl/i_decode_issue.sv - I-type decode/issue stage with register file and RAW scoreboard
// Optional macro DECODE_BYPASS_EN forwards same-cycle writeback data into in1.
module i_decode_issue #(
  parameter int         XLEN      = 32,
  parameter int         NREGS     = 32,
  parameter logic [6:0] OPC_ITYPE = 7'b0010011
) (
  input logic             clk,
  input logic             rst_n,
  i_decode_issue_if.slave bus
);
  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] sb;
  logic [4:0]       rs1;
  logic [4:0]       rd_in;
  logic [6:0]       opc;
  logic [XLEN-1:0]  rf_val;
  logic [XLEN-1:0]  rs1_val;
  logic             wb_hit;
  logic             hazard;
  logic             accept;

  assign rs1    = bus.in_instr[19:15];
  assign rd_in  = bus.in_instr[11:7];
  assign opc    = bus.in_instr[6:0];
  assign rf_val = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign wb_hit = bus.wb_en && (bus.wb_rd == rs1) && (rs1 != 5'd0);

`ifdef DECODE_BYPASS_EN
  assign hazard  = sb[rs1] && !wb_hit;
  assign rs1_val = wb_hit ? bus.wb_data : rf_val;
`else
  assign hazard  = sb[rs1];
  assign rs1_val = rf_val;
`endif

  assign bus.in_ready = !hazard && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      sb            <= '0;
      bus.out_valid <= 1'b0;
      bus.illegal   <= 1'b0;
      bus.opcode    <= '0;
      bus.funct3    <= '0;
      bus.imm       <= '0;
      bus.in1       <= '0;
      bus.rd        <= '0;
    end else begin
      bus.illegal <= 1'b0;
      if (bus.wb_en && bus.wb_rd != 5'd0) regs[bus.wb_rd] <= bus.wb_data;
      if (bus.wb_en) sb[bus.wb_rd] <= 1'b0;
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      // Issue comes after the writeback clear so a new producer's set wins.
      if (accept) begin
        if (opc == OPC_ITYPE) begin
          bus.out_valid <= 1'b1;
          bus.opcode    <= opc;
          bus.funct3    <= bus.in_instr[14:12];
          bus.imm       <= bus.in_instr[31:20];
          bus.in1       <= rs1_val;
          bus.rd        <= rd_in;
          if (rd_in != 5'd0) sb[rd_in] <= 1'b1;
        end else begin
          bus.illegal <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_i_decode_issue.sv
// tb/tb_i_decode_issue.sv - directed self-checking bench for i_decode_issue
module tb_i_decode_issue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;

  i_decode_issue_if bus ();

  i_decode_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    bus.wb_en = 1'b1; bus.wb_rd = r; bus.wb_data = d;
    tick();
    bus.wb_en = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_instr = 0; bus.out_ready = 1;
    bus.wb_en = 0; bus.wb_rd = 0; bus.wb_data = 0;
    tick(); tick();
    rst_n = 1'b1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); else passed++;
    total++; if (bus.illegal !== 1'b0) $display("FAIL rst_illegal got %b exp 0", bus.illegal); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); else passed++;
    total++; if (bus.in1 !== 32'h0 || bus.opcode !== 7'h0) $display("FAIL rst_fields got in1=%h opc=%h exp 0", bus.in1, bus.opcode); else passed++;
    wb(5'd5, 32'h0000_0055);
    bus.out_ready = 0; bus.in_valid = 1; bus.in_instr = enc_i(12'd1, 5'd0, 3'd0, 5'd7);
    tick();
    bus.in_valid = 0;
    total++; if (bus.out_valid !== 1'b1) $display("FAIL pre_rst_valid got %b exp 1", bus.out_valid); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b exp 0", bus.out_valid); else passed++;
    total++; if (bus.illegal !== 1'b0) $display("FAIL midrst_illegal got %b exp 0", bus.illegal); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL midrst_in_ready got %b exp 1", bus.in_ready); else passed++;
    tick();
    rst_n = 1'b1; bus.out_ready = 1;
    bus.in_valid = 1; bus.in_instr = enc_i(12'd0, 5'd5, 3'd0, 5'd8);
    tick();
    bus.in_valid = 0;
    total++; if (bus.out_valid !== 1'b1 || bus.rd !== 5'd8) $display("FAIL post_rst_issue got v=%b rd=%0d exp v=1 rd=8", bus.out_valid, bus.rd); else passed++;
    total++; if (bus.in1 !== 32'h0) $display("FAIL post_rst_x5 got %h exp 0", bus.in1); else passed++;
    tick();
  endtask

  task automatic test_basic();
    wb(5'd1, 32'h0000_1234);
    bus.in_valid = 1; bus.in_instr = 32'hFFF0_8113;
    tick();
    bus.in_valid = 0;
    total++; if (bus.out_valid !== 1'b1) $display("FAIL basic_valid got %b exp 1", bus.out_valid); else passed++;
    total++; if (bus.opcode !== 7'b0010011) $display("FAIL basic_opcode got %h exp 13", bus.opcode); else passed++;
    total++; if (bus.funct3 !== 3'd0) $display("FAIL basic_funct3 got %0d exp 0", bus.funct3); else passed++;
    total++; if (bus.imm !== 12'hFFF) $display("FAIL basic_imm got %h exp fff", bus.imm); else passed++;
    total++; if (bus.in1 !== 32'h1234) $display("FAIL basic_in1 got %h exp 1234", bus.in1); else passed++;
    total++; if (bus.rd !== 5'd2) $display("FAIL basic_rd got %0d exp 2", bus.rd); else passed++;
    tick();
    total++; if (bus.out_valid !== 1'b0 || bus.imm !== 12'hFFF) $display("FAIL basic_drain got v=%b imm=%h exp v=0 imm=fff", bus.out_valid, bus.imm); else passed++;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_instr = enc_i(12'h0F0, 5'd1, 3'd7, 5'd9);
    tick();
    bus.in_instr = enc_i(12'd3, 5'd1, 3'd2, 5'd11);
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %b exp 0", i, bus.in_ready); else passed++;
      total++; if (bus.out_valid !== 1'b1 || bus.rd !== 5'd9 || bus.funct3 !== 3'd7 || bus.imm !== 12'h0F0)
        $display("FAIL bp_hold[%0d] got v=%b rd=%0d f3=%0d imm=%h exp v=1 rd=9 f3=7 imm=0f0", i, bus.out_valid, bus.rd, bus.funct3, bus.imm);
      else passed++;
      tick();
    end
    bus.out_ready = 1;
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", bus.in_ready); else passed++;
    tick();
    bus.in_valid = 0;
    total++; if (bus.out_valid !== 1'b1 || bus.rd !== 5'd11 || bus.funct3 !== 3'd2 || bus.imm !== 12'd3 || bus.in1 !== 32'h1234)
      $display("FAIL bp_second got v=%b rd=%0d f3=%0d imm=%h in1=%h exp v=1 rd=11 f3=2 imm=003 in1=1234", bus.out_valid, bus.rd, bus.funct3, bus.imm, bus.in1);
    else passed++;
    tick();
  endtask

  task automatic test_raw();
    bus.in_valid = 1; bus.in_instr = enc_i(12'd5, 5'd0, 3'd0, 5'd3);
    tick();
    bus.in_instr = enc_i(12'd1, 5'd3, 3'd0, 5'd4);
    #1;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL raw_stall got %b exp 0", bus.in_ready); else passed++;
    tick();
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) $display("FAIL raw_stall2 got v=%b rdy=%b exp v=0 rdy=0", bus.out_valid, bus.in_ready); else passed++;
    bus.wb_en = 1; bus.wb_rd = 5'd3; bus.wb_data = 32'd5;
    #1;
`ifdef DECODE_BYPASS_EN
    total++; if (bus.in_ready !== 1'b1) $display("FAIL raw_bypass_ready got %b exp 1", bus.in_ready); else passed++;
    tick();
    bus.wb_en = 0; bus.in_valid = 0;
`else
    total++; if (bus.in_ready !== 1'b0) $display("FAIL raw_wb_cycle_ready got %b exp 0", bus.in_ready); else passed++;
    tick();
    bus.wb_en = 0;
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL raw_after_wb_ready got %b exp 1", bus.in_ready); else passed++;
    tick();
    bus.in_valid = 0;
`endif
    total++; if (bus.out_valid !== 1'b1 || bus.in1 !== 32'd5 || bus.rd !== 5'd4)
      $display("FAIL raw_issue got v=%b in1=%h rd=%0d exp v=1 in1=5 rd=4", bus.out_valid, bus.in1, bus.rd);
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1; bus.in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      bus.in_instr = enc_i(12'(i + 1), 5'd1, 3'd0, 5'(12 + i));
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.rd !== 5'(12 + i) || bus.imm !== 12'(i + 1))
        $display("FAIL b2b[%0d] got v=%b rd=%0d imm=%h exp v=1 rd=%0d imm=%0d", i, bus.out_valid, bus.rd, bus.imm, 12 + i, i + 1);
      else passed++;
    end
    bus.in_valid = 0;
    tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_drain got %b exp 0", bus.out_valid); else passed++;
  endtask

  task automatic test_illegal_x0();
    wb(5'd2, 32'h0000_0002);
    bus.in_valid = 1; bus.in_instr = 32'h0031_00B3;
    tick();
    bus.in_valid = 0;
    total++; if (bus.illegal !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL illegal_pulse got ill=%b v=%b exp ill=1 v=0", bus.illegal, bus.out_valid); else passed++;
    tick();
    total++; if (bus.illegal !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL illegal_end got ill=%b v=%b exp ill=0 v=0", bus.illegal, bus.out_valid); else passed++;
    bus.in_instr = enc_i(12'd0, 5'd1, 3'd0, 5'd15);
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL illegal_sb_untouched got %b exp 1", bus.in_ready); else passed++;
    wb(5'd0, 32'hDEAD_BEEF);
    bus.in_valid = 1; bus.in_instr = enc_i(12'd0, 5'd0, 3'd0, 5'd6);
    tick();
    bus.in_valid = 0;
    total++; if (bus.out_valid !== 1'b1 || bus.in1 !== 32'h0) $display("FAIL x0_read got v=%b in1=%h exp v=1 in1=0", bus.out_valid, bus.in1); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_raw();
    test_back_to_back();
    test_illegal_x0();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/i_decode_issue.md
Name: i_decode_issue

Overview:
- Decode/issue stage directly upstream of the I-type ALU (`i_type`).
- Accepts 32-bit instruction words over a valid/ready handshake and reads rs1 from an internal 32x32 register file.
- Drives registered opcode/funct3/imm/in1/rd to the ALU.
- Writeback port from downstream updates the register file; a per-register scoreboard stalls issue on RAW hazards.

Parameters:
XLEN, 32, data width of register file and in1/wb_data
NREGS, 32, number of architectural registers (x0 hardwired to zero)
OPC_ITYPE, 7'b0010011, only opcode this stage issues

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  instruction word valid
in_ready  output  1  stage can accept instruction this cycle
in_instr  input  32  RV32 instruction word
out_valid  output  1  issue register holds valid op for ALU
out_ready  input  1  ALU/downstream accepts op
opcode  output  7  instr[6:0], registered
funct3  output  3  instr[14:12], registered
imm  output  12  instr[31:20], registered, unextended
in1  output  XLEN  rs1 value, registered
rd  output  5  instr[11:7], registered
illegal  output  1  one-cycle pulse: non-I-type word consumed and dropped
wb_en  input  1  writeback strobe
wb_rd  input  5  writeback register index
wb_data  input  XLEN  writeback value

Behaviour:
- Reset (async assert, sync release): out_valid=0, illegal=0, opcode/funct3/imm/in1/rd=0, all registers=0, all scoreboard bits=0. Reset mid-stall drops the pending instruction.
- Register file: written on clk edge when wb_en && wb_rd!=0. x0 always reads 0; writes to x0 are ignored.
- Scoreboard: 1 bit per register.
  - Set on issue of an instruction with rd!=0.
  - Cleared on wb_en for wb_rd.
  - Same-cycle set and clear of the same index: set wins (new producer).
  - Bit 0 is never set.
- rs1 = in_instr[19:15].
- hazard = sb[rs1] && !(wb_en && wb_rd==rs1). With DECODE_BYPASS_EN undefined, hazard = sb[rs1].
- in_ready = !hazard && (!out_valid || out_ready). Combinational, no dependency on in_valid.
- Accept = in_valid && in_ready.
- Accept with opcode==OPC_ITYPE:
  - Next edge loads the output register, out_valid=1, sets sb[rd].
  - Latency 1 cycle from accept to out_valid.
- Accept with any other opcode: word consumed; out_valid=0 next cycle unless the prior op is held; illegal=1 for exactly one cycle; scoreboard untouched.
- out_valid && !out_ready: all outputs hold stable; no new accept.
- out_valid && out_ready && no accept: out_valid=0 next cycle; data fields hold their last value.
- Back-to-back throughput: 1 op/cycle when no hazard and out_ready=1.
- funct3/imm passed unmodified. Sign-extension and shamt handling belong to the ALU.
- Instruction with rd==0 issues normally; no scoreboard effect.

Optional Feature:
- DECODE_BYPASS_EN defined:
  - Same-cycle writeback matching rs1 clears the hazard.
  - in1 is loaded from wb_data instead of the register file.
  - Dependent op issues in the writeback cycle.
- DECODE_BYPASS_EN undefined:
  - No forwarding; issue waits until the cycle after writeback.
  - Costs one extra stall cycle per RAW dependency.
  - in1 always comes from the register file.

Test Plan:
- Reset: assert rst_n=0 mid-operation with out_valid=1 -> out_valid=0, illegal=0, in_ready=1 immediately; reading x5 after release yields in1=0.
- Basic issue: writeback x1=32'h0000_1234, then addi x2,x1,-1 (32'hFFF08113) -> next cycle out_valid=1, opcode=7'b0010011, funct3=0, imm=12'hFFF, in1=32'h1234, rd=2.
- Backpressure: hold out_ready=0 for 3 cycles with a second valid instruction waiting -> outputs stable, in_ready=0; out_ready=1 -> second op issues next cycle.
- RAW hazard: issue addi x3,x0,5, then addi x4,x3,1 with no writeback -> in_ready=0. Drive wb_en, wb_rd=3, wb_data=5:
  - with DECODE_BYPASS_EN: issues that cycle, in1=5.
  - without: issues one cycle later, in1=5.
- Illegal/x0: send add x1,x2,x3 (opcode 0110011) -> illegal=1 for one cycle, out_valid stays 0. Send wb_en, wb_rd=0, wb_data=32'hDEAD_BEEF, then addi x6,x0,0 -> in1=0.
